// File: rtl/motor_sched_pkg.sv
// Shared types and constants for the motor command frame scheduler.
// Optional clamp feature: MOTOR_SCHED_LIMIT_EN (see motor_cmd_scheduler).
package motor_sched_pkg;

  localparam int POS_W = 16;
  localparam logic [POS_W-1:0] POS_MAX_DEFAULT = 16'hFFF0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

  // Bit positions inside the sticky flag vector.
  localparam int FLAG_OVERRUN   = 0;
  localparam int FLAG_TICK_MISS = 1;
  localparam int FLAG_LIMIT     = 2;
  localparam int N_FLAGS        = 3;

endpackage

// File: rtl/motor_cmd_slot.sv
// One per-motor shadow slot: 16-bit target position plus pending bit.
// A host write in the same cycle as dispatch wins: the new value stays pending.
module motor_cmd_slot
  import motor_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [POS_W-1:0] wr_data_i,
  input  logic             clr_i,
  output logic [POS_W-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [POS_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (wr_en_i) begin
      data_d  = wr_data_i;
      valid_d = 1'b1;
    end else if (clr_i) begin
      valid_d = 1'b0;
    end
  end

  // Overwriting a pending value is only a loss if it is not being dispatched now.
  assign overrun_o = wr_en_i & valid_q & ~clr_i;
  assign data_o    = data_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/motor_cmd_scheduler.sv
// Frame scheduler: host writes per-motor targets; each clock_4ms tick scans slots
// 0..N_MOTORS-1 and strobes pending ones onto new_pos. Macro: MOTOR_SCHED_LIMIT_EN.
module motor_cmd_scheduler
  import motor_sched_pkg::*;
#(
  parameter int               N_MOTORS = 8,
  parameter int               IDX_W    = 3,
  parameter logic [POS_W-1:0] POS_MAX  = POS_MAX_DEFAULT
) (
  input  logic                CLK_10MHZ,
  input  logic                RST_N,
  input  logic                clock_4ms,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IDX_W-1:0]    cmd_idx,
  input  logic [POS_W-1:0]    cmd_pos,
  input  logic                clr_flags,
  output logic [POS_W-1:0]    new_pos,
  output logic [N_MOTORS-1:0] new_pos_sig,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun_flag,
  output logic                tick_miss,
  output logic                limit_flag,
  output sched_state_e        dbg_state
);

`ifdef MOTOR_SCHED_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  sched_state_e        state_q, state_d;
  logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;
  logic                ready_q;
  logic [POS_W-1:0]    new_pos_q, new_pos_d;
  logic [N_MOTORS-1:0] sig_q, sig_d;
  logic [N_FLAGS-1:0]  flags_q, flags_d, flag_evt;

  logic                wr_fire, idx_ok, over_max, disp;
  logic [POS_W-1:0]    wr_pos;
  logic [POS_W-1:0]    slot_data [N_MOTORS];
  logic [N_MOTORS-1:0] slot_valid, slot_wr, slot_clr, slot_ovr;

  // Handshake: a command transfers on any cycle with cmd_valid && cmd_ready;
  // cmd_ready rises one edge after reset release and never drops afterwards.
  assign wr_fire  = cmd_valid & ready_q;
  assign idx_ok   = int'(cmd_idx) < N_MOTORS;
  assign over_max = LIMIT_EN && (cmd_pos > POS_MAX);
  assign wr_pos   = over_max ? POS_MAX : cmd_pos;
  assign disp     = (state_q == ST_SCAN) && slot_valid[scan_idx_q];

  for (genvar g = 0; g < N_MOTORS; g++) begin : g_slot
    assign slot_wr[g]  = wr_fire && idx_ok && (cmd_idx == IDX_W'(g));
    assign slot_clr[g] = (state_q == ST_SCAN) && (scan_idx_q == IDX_W'(g)) && slot_valid[g];

    motor_cmd_slot u_slot (
      .clk       (CLK_10MHZ),
      .rst_n     (RST_N),
      .wr_en_i   (slot_wr[g]),
      .wr_data_i (wr_pos),
      .clr_i     (slot_clr[g]),
      .data_o    (slot_data[g]),
      .valid_o   (slot_valid[g]),
      .overrun_o (slot_ovr[g])
    );
  end

  always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      scan_idx_q <= '0;
      ready_q    <= 1'b0;
      new_pos_q  <= '0;
      sig_q      <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      ready_q    <= 1'b1;
      new_pos_q  <= new_pos_d;
      sig_q      <= sig_d;
      flags_q    <= flags_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    scan_idx_d = scan_idx_q;
    new_pos_d  = new_pos_q;
    sig_d      = '0;
    case (state_q)
      ST_IDLE: begin
        if (clock_4ms) begin
          state_d    = ST_SCAN;
          scan_idx_d = '0;
        end
      end
      ST_SCAN: begin
        if (disp) begin
          new_pos_d             = slot_data[scan_idx_q];
          sig_d[scan_idx_q]     = 1'b1;
        end
        if (scan_idx_q == IDX_W'(N_MOTORS - 1)) state_d = ST_DONE;
        else                                    scan_idx_d = scan_idx_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky flags: an event in the same cycle as clr_flags leaves the flag set.
  always_comb begin
    flag_evt                 = '0;
    flag_evt[FLAG_OVERRUN]   = (|slot_ovr) | (wr_fire & ~idx_ok);
    flag_evt[FLAG_TICK_MISS] = clock_4ms & (state_q != ST_IDLE);
    flag_evt[FLAG_LIMIT]     = wr_fire & idx_ok & over_max;
    flags_d                  = (flags_q & ~{N_FLAGS{clr_flags}}) | flag_evt;
  end

  assign cmd_ready    = ready_q;
  assign new_pos      = new_pos_q;
  assign new_pos_sig  = sig_q;
  assign busy         = (state_q == ST_SCAN) || (state_q == ST_DONE);
  assign frame_done   = (state_q == ST_DONE);
  assign overrun_flag = flags_q[FLAG_OVERRUN];
  assign tick_miss    = flags_q[FLAG_TICK_MISS];
  assign limit_flag   = flags_q[FLAG_LIMIT];
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Directed bench for motor_cmd_scheduler; expected values are hand-derived.
// Inputs change #1 after the rising edge; outputs are checked at that point too.
module tb_motor_cmd_scheduler;
  import motor_sched_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clock_4ms = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_idx = '0;
  logic [15:0]  cmd_pos = '0;
  logic         clr_flags = 1'b0;
  logic [15:0]  new_pos;
  logic [N-1:0] new_pos_sig;
  logic         busy, frame_done, overrun_flag, tick_miss, limit_flag;
  sched_state_e dbg_state;

  int           checks = 0;
  int           errors = 0;
  logic [15:0]  last_pos = '0;
  logic [15:0]  exp_pos [N];
  logic [N-1:0] exp_mask;

  motor_cmd_scheduler dut (
    .CLK_10MHZ    (clk),
    .RST_N        (rst_n),
    .clock_4ms    (clock_4ms),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_idx      (cmd_idx),
    .cmd_pos      (cmd_pos),
    .clr_flags    (clr_flags),
    .new_pos      (new_pos),
    .new_pos_sig  (new_pos_sig),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun_flag (overrun_flag),
    .tick_miss    (tick_miss),
    .limit_flag   (limit_flag),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  always #50 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cmd(input logic [2:0] idx, input logic [15:0] pos);
    cmd_valid = 1'b1;
    cmd_idx   = idx;
    cmd_pos   = pos;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
  endtask

  // Tick at cycle t, then check every cycle up to t+N+2 against exp_mask/exp_pos.
  task automatic scan_frame(input string tag);
    clock_4ms = 1'b1;
    step();
    clock_4ms = 1'b0;
    check_val({tag, ":busy_t1"}, 32'(busy), 32'd1);
    check_val({tag, ":sig_t1"}, 32'(new_pos_sig), 32'd0);
    for (int c = 2; c <= N + 1; c++) begin
      step();
      if (exp_mask[c-2]) begin
        last_pos = exp_pos[c-2];
        check_val($sformatf("%s:sig_k%0d", tag, c - 2), 32'(new_pos_sig), 32'(1 << (c - 2)));
      end else begin
        check_val($sformatf("%s:nosig_k%0d", tag, c - 2), 32'(new_pos_sig), 32'd0);
      end
      check_val($sformatf("%s:pos_k%0d", tag, c - 2), 32'(new_pos), 32'(last_pos));
      check_val($sformatf("%s:done_k%0d", tag, c - 2), 32'(frame_done), 32'(c == N + 1));
    end
    step();
    check_val({tag, ":idle_busy"}, 32'(busy), 32'd0);
    check_val({tag, ":idle_sig"}, 32'(new_pos_sig), 32'd0);
    check_val({tag, ":idle_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    // 1: reset
    #20;
    check_val("rst_ready", 32'(cmd_ready), 32'd0);
    check_val("rst_sig", 32'(new_pos_sig), 32'd0);
    check_val("rst_pos", 32'(new_pos), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_flags", {29'd0, overrun_flag, tick_miss, limit_flag}, 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    step();
    step();
    rst_n = 1'b1;
    check_val("rel_ready_before_edge", 32'(cmd_ready), 32'd0);
    step();
    check_val("rel_ready_after_edge", 32'(cmd_ready), 32'd1);

    // 2: two pending slots, then an empty frame
    write_cmd(3'd2, 16'h0100);
    write_cmd(3'd5, 16'h0200);
    for (int i = 0; i < N; i++) exp_pos[i] = '0;
    exp_pos[2] = 16'h0100;
    exp_pos[5] = 16'h0200;
    exp_mask = 8'b0010_0100;
    scan_frame("t2a");
    exp_mask = '0;
    scan_frame("t2b");
    check_val("t2_overrun", 32'(overrun_flag), 32'd0);

    // 3: overwrite before dispatch
    write_cmd(3'd1, 16'h0010);
    write_cmd(3'd1, 16'h0020);
    check_val("t3_overrun_set", 32'(overrun_flag), 32'd1);
    exp_pos[1] = 16'h0020;
    exp_mask = 8'b0000_0010;
    scan_frame("t3");
    clear_flags();
    check_val("t3_overrun_clr", 32'(overrun_flag), 32'd0);

    // 5: write to idx3 in the cycle it is dispatched
    write_cmd(3'd3, 16'h0044);
    clock_4ms = 1'b1;
    step();                 // t+1, scan_idx=0
    clock_4ms = 1'b0;
    step();                 // t+2
    step();                 // t+3
    step();                 // t+4, scan_idx=3
    write_cmd(3'd3, 16'h0055);  // now t+5
    check_val("t5_sig_old", 32'(new_pos_sig), 32'h08);
    check_val("t5_pos_old", 32'(new_pos), 32'h0044);
    last_pos = 16'h0044;
    for (int i = 0; i < 5; i++) step();
    check_val("t5_idle", 32'(busy), 32'd0);
    check_val("t5_no_overrun", 32'(overrun_flag), 32'd0);
    exp_pos[3] = 16'h0055;
    exp_mask = 8'b0000_1000;
    scan_frame("t5");
    check_val("t5_no_overrun2", 32'(overrun_flag), 32'd0);

    // 4: second tick during scan is ignored
    write_cmd(3'd0, 16'h0AAA);
    clock_4ms = 1'b1;
    step();                 // t+1
    clock_4ms = 1'b0;
    step();                 // t+2
    check_val("t4_sig0", 32'(new_pos_sig), 32'h01);
    check_val("t4_pos0", 32'(new_pos), 32'h0AAA);
    last_pos = 16'h0AAA;
    step();                 // t+3
    check_val("t4_miss_before", 32'(tick_miss), 32'd0);
    clock_4ms = 1'b1;
    step();                 // t+4
    clock_4ms = 1'b0;
    check_val("t4_miss_set", 32'(tick_miss), 32'd1);
    for (int c = 5; c <= N + 1; c++) step();
    check_val("t4_done", 32'(frame_done), 32'd1);
    step();
    check_val("t4_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("t4_no_restart", {23'd0, busy, new_pos_sig}, 32'd0);
    end
    clear_flags();
    check_val("t4_miss_clr", 32'(tick_miss), 32'd0);

    // 6: position limit
    write_cmd(3'd4, 16'hFFFF);
`ifdef MOTOR_SCHED_LIMIT_EN
    exp_pos[4] = 16'hFFF0;
    check_val("t6_limit", 32'(limit_flag), 32'd1);
`else
    exp_pos[4] = 16'hFFFF;
    check_val("t6_limit", 32'(limit_flag), 32'd0);
`endif
    exp_mask = 8'b0001_0000;
    scan_frame("t6");

    // Reset in the middle of a scan
    write_cmd(3'd6, 16'h1234);
    write_cmd(3'd7, 16'h4321);
    clock_4ms = 1'b1;
    step();
    clock_4ms = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_val("rm_sig", 32'(new_pos_sig), 32'd0);
    check_val("rm_busy", 32'(busy), 32'd0);
    check_val("rm_ready", 32'(cmd_ready), 32'd0);
    check_val("rm_pos", 32'(new_pos), 32'd0);
    last_pos = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_val("rm_hold_sig", 32'(new_pos_sig), 32'd0);
    end
    rst_n = 1'b1;
    step();
    check_val("rm_ready_back", 32'(cmd_ready), 32'd1);
    exp_mask = '0;
    scan_frame("rm_empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
